seg7_mux_99: RTL and testbench

- Downstream display stage for the 0–99 timer counter.
- Takes the counter's 8-bit binary value and drives a two-digit, common-segment, time-multiplexed seven-segment display.
- Samples the value once per display frame, converts it to two decimal digits and scans the ones and tens digits in turn.
- Inserts a blanking gap between the two digits to prevent ghosting.
- Flags inputs outside 0–99.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_mux_99_if.sv | 24 ++
 rtl/seg7_decode.sv | 31 +++
 rtl/seg7_mux_99.sv | 127 ++++++++++++
 tb/tb_seg7_mux_99.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the two-digit multiplexed seven-segment display stage.
// Segment patterns are logical (active-high) and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam int MAX_VALUE = 99;

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_GAP1 = 2'd1,
        S_TENS = 2'd2,
        S_GAP2 = 2'd3
    } state_t;

endpackage

// File: rtl/seg7_mux_99_if.sv
// Signal bundle between the counter side (master) and the display stage (slave).
interface seg7_mux_99_if;
    import seg7_pkg::*;

    // No handshake: value is free-running and only looked at on the frame_start edge;
    // seg/dig are pin-level, err/frame_start are logical, state_dbg mirrors the scan FSM.
    logic [7:0] value;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       err;
    logic       frame_start;
    state_t     state_dbg;

    modport master (
        output value,
        input  seg, dig, err, frame_start, state_dbg
    );

    modport slave (
        input  value,
        output seg, dig, err, frame_start, state_dbg
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder; dash overrides the digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        if (dash) begin
            pattern = SEG_DASH;
        end else begin
            case (digit)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seg7_mux_99.sv
// Two-digit time-multiplexed display driver: samples value once per frame and scans
// ones, blank, tens, blank, with optional leading-zero blanking and pin polarity.
module seg7_mux_99
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int LZB            = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic          clk,
    input  logic          reset,
    seg7_mux_99_if.slave  bus
);

    localparam int MAXP  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tens_q, tens_d;
    logic             err_q, err_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       dig_q, dig_d;
    logic             fs_q, fs_d;

    logic [3:0] tens_live, ones_live;
    logic       oor_live;
    logic       last, sample, tens_blank;
    logic [3:0] dec_digit;
    logic       dec_dash;
    logic [6:0] dec_pattern;

    // Binary to BCD by threshold comparison; ones is exact modulo 16 since it is < 10.
    always_comb begin
        tens_live = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (bus.value >= 8'(i * 10)) tens_live = 4'(i);
        end
        ones_live = bus.value[3:0] - 4'(tens_live * 4'd10);
        oor_live  = (bus.value > 8'(MAX_VALUE));
    end

    seg7_decode u_decode (
        .digit   (dec_digit),
        .dash    (dec_dash),
        .pattern (dec_pattern)
    );

    always_comb begin
        last    = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            S_ONES, S_TENS: last = (cnt_q == R_LAST);
            default:        last = (cnt_q == B_LAST);
        endcase
        if (last) begin
            cnt_d = '0;
            case (state_q)
                S_ONES:  state_d = S_GAP1;
                S_GAP1:  state_d = S_TENS;
                S_TENS:  state_d = S_GAP2;
                default: state_d = S_ONES;
            endcase
        end

        sample = last && (state_q == S_GAP2);
        tens_d = sample ? tens_live : tens_q;
        err_d  = sample ? oor_live : err_q;
        fs_d   = sample;

        // The single decoder serves the live ones digit on the sample edge, else the shadow tens.
        dec_digit  = sample ? ones_live : tens_q;
        dec_dash   = sample ? oor_live : err_q;
        tens_blank = (LZB != 0) && !err_q && (tens_q == 4'd0);

        seg_d = SEG_OFF;
        dig_d = 2'b00;
        case (state_d)
            S_ONES: begin
                seg_d = sample ? dec_pattern : seg_q;
                dig_d = 2'b01;
            end
            S_TENS: begin
                if (!tens_blank) begin
                    seg_d = dec_pattern;
                    dig_d = 2'b10;
                end
            end
            default: begin
                seg_d = SEG_OFF;
                dig_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_GAP2;
            cnt_q   <= B_LAST;
            tens_q  <= 4'd0;
            err_q   <= 1'b0;
            seg_q   <= SEG_OFF;
            dig_q   <= 2'b00;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            err_q   <= err_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.seg         = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign bus.dig         = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;
    assign bus.err         = err_q;
    assign bus.frame_start = fs_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_seg7_mux_99.sv
// Bench for seg7_mux_99: three lockstep instances (LZB=1, LZB=0, active-low pins)
// checked frame by frame against a behavioural model through an expected queue.
module tb_seg7_mux_99;
    import seg7_pkg::*;

    localparam int R = 4;
    localparam int B = 1;
    localparam int F = 2 * (R + B);

    typedef struct {
        logic [7:0] value;
        bit         chg;
        logic [7:0] mid_value;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] value;
    int         tests;
    int         fails;
    logic [21:0] exp_q[$];
    vec_t       vecs[12];

    seg7_mux_99_if bus_a ();
    seg7_mux_99_if bus_b ();
    seg7_mux_99_if bus_c ();

    assign bus_a.value = value;
    assign bus_b.value = value;
    assign bus_c.value = value;

    seg7_mux_99 #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZB(1),
                  .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    seg7_mux_99 #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZB(0),
                  .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    seg7_mux_99 #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZB(1),
                  .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Word layout {frame_start, err, dig[1:0], seg[6:0]}, logical polarity; k = edge - 1.
    function automatic logic [10:0] model(input logic [7:0] v, input int k, input bit lzb);
        int         t, o;
        bit         oor;
        logic [6:0] s;
        logic [1:0] d;
        oor = (v > 8'd99);
        t   = int'(v) / 10;
        o   = int'(v) % 10;
        s   = 7'h00;
        d   = 2'b00;
        if (k < R) begin
            d = 2'b01;
            s = oor ? 7'h40 : seg_of(o);
        end else if (k >= R + B && k < 2 * R + B) begin
            if (oor) begin
                d = 2'b10;
                s = 7'h40;
            end else if (!(lzb && t == 0)) begin
                d = 2'b10;
                s = seg_of(t);
            end
        end
        return {(k == 0), oor, d, s};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp,
                         input logic [7:0] v, input int k);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s value=%0d edge=%0d got {fs,err,dig,seg}=%h expected %h",
                     name, v, k + 1, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_a"}, {bus_a.frame_start, bus_a.err, bus_a.dig, bus_a.seg},
              11'h000, value, -1);
        check({name, "_c_pins"}, {bus_c.frame_start, bus_c.err, bus_c.dig, bus_c.seg},
              {1'b0, 1'b0, 2'b11, 7'h7F}, value, -1);
        tests++;
        if (bus_a.state_dbg !== S_GAP2) begin
            fails++;
            $display("FAIL %s_state got %0d expected %0d", name, bus_a.state_dbg, S_GAP2);
        end
    endtask

    // Runs one frame from a negedge; abort_k >= 0 asserts reset just before edge abort_k+1.
    task automatic run_frame(input logic [7:0] v, input bit chg, input logic [7:0] mid_v,
                             input int abort_k);
        logic [21:0] w;
        logic [10:0] ea, eb, ec;
        value = v;
        for (int k = 0; k < F; k++) exp_q.push_back({model(v, k, 1'b0), model(v, k, 1'b1)});
        for (int k = 0; k < F; k++) begin
            if (k == abort_k) begin
                reset = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_reset("mid_reset");
                exp_q.delete();
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL queue_empty value=%0d edge=%0d", v, k + 1);
            end else begin
                w  = exp_q.pop_front();
                ea = w[10:0];
                eb = w[21:11];
                ec = {ea[10:9], ~ea[8:7], ~ea[6:0]};
                check("lzb1", {bus_a.frame_start, bus_a.err, bus_a.dig, bus_a.seg}, ea, v, k);
                check("lzb0", {bus_b.frame_start, bus_b.err, bus_b.dig, bus_b.seg}, eb, v, k);
                check("pins_low", {bus_c.frame_start, bus_c.err, bus_c.dig, bus_c.seg}, ec, v, k);
            end
            if (chg && k == 1) value = mid_v;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        vecs[0]  = '{8'd57,  1'b0, 8'd0};
        vecs[1]  = '{8'd5,   1'b0, 8'd0};
        vecs[2]  = '{8'd0,   1'b0, 8'd0};
        vecs[3]  = '{8'd120, 1'b0, 8'd0};
        vecs[4]  = '{8'd99,  1'b0, 8'd0};
        vecs[5]  = '{8'd57,  1'b1, 8'd99};
        vecs[6]  = '{8'd99,  1'b0, 8'd0};
        vecs[7]  = '{8'd100, 1'b0, 8'd0};
        vecs[8]  = '{8'd10,  1'b0, 8'd0};
        vecs[9]  = '{8'd255, 1'b0, 8'd0};
        vecs[10] = '{8'd9,   1'b0, 8'd0};
        vecs[11] = '{8'd42,  1'b1, 8'd3};

        reset = 1'b0;
        value = 8'd57;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        reset = 1'b1;

        foreach (vecs[i]) run_frame(vecs[i].value, vecs[i].chg, vecs[i].mid_value, -1);

        for (int i = 0; i < 4; i++) run_frame(8'($urandom_range(0, 150)), 1'b0, 8'd0, -1);

        // Abort an out-of-range frame mid tens phase, then restart cleanly.
        run_frame(8'd120, 1'b0, 8'd0, 6);
        run_frame(8'd57, 1'b0, 8'd0, -1);
        run_frame(8'd57, 1'b0, 8'd0, 0);
        run_frame(8'd83, 1'b0, 8'd0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
